uart_rx_gen2: RTL and testbench
===============================

# uart_rx_gen2

Parametrised second-generation UART receiver that replaces the fixed 8-bit receive path in the UART wrapper. It oversamples the serial line with a runtime prescale and uses 3-sample majority voting. It supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits, and flags framing, parity and start-glitch errors. Its outputs feed the data synchroniser and the system controller.

## Interface
- DATAWIDTH, 8, number of data bits per frame; legal range 5–9.
- CLK  input  1  receive oversampling clock; the block's only clock.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line; idles high.
- PRESCALE  input  6  oversampling ratio, in CLK cycles per bit; values below 4 are treated as 4.
- PAR_EN  input  1  1 = a parity bit follows the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits, 0 = one stop bit.
- P_DATA  output  DATAWIDTH  last good frame's data; LSB is the first bit received.
- DATA_VALID  output  1  one-cycle pulse; P_DATA has just been updated.
- PARITY_ERROR  output  1  one-cycle pulse on a parity mismatch.
- STOP_ERROR  output  1  one-cycle pulse when a stop bit is voted 0.
- STR_GLITCH  output  1  one-cycle pulse when a start bit is voted 1.
- BREAK_DET  output  1  one-cycle pulse on a break condition (see Configuration).

## Operation
- RX_IN passes through a 2-flop synchroniser; all logic below uses the synchronised line `rxs`.
- Bit counter `edge_cnt` runs 0..P-1 within each bit. Let h = P>>1.
  - Samples are taken at counts h-1, h and h+1.
  - The bit value is the majority of the three samples and is decided at count h+1.
- PRESCALE, PAR_EN, PAR_TYP and STOP2 are latched on leaving IDLE. Input changes during a frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, STOP_B, BRK_WAIT.
- IDLE → START when `rxs` = 0. That cycle is count 0 of the start bit.
- START:
  - Voted 1 → pulse STR_GLITCH and go to IDLE at the decision cycle.
  - Voted 0 → go to DATA at count P-1.
- DATA: DATAWIDTH bits are shifted into a shift register, LSB first. After the last bit, at count P-1, go to PARITY if PAR_EN = 1, otherwise go to STOP.
- PARITY: expected parity bit = XOR of the data bits, XOR PAR_TYP. A mismatch is recorded.
- STOP:
  - If STOP2 = 1 → go to STOP_B at count P-1.
  - Otherwise the frame ends at the STOP decision cycle.
- STOP_B: the frame ends at its decision cycle.
- A stop bit voted 0 in either stop state records a stop error.
- Frame end, in the cycle after the final stop decision:
  - If no errors: P_DATA ← shift register and DATA_VALID = 1.
  - Otherwise: pulse the recorded error flag(s); P_DATA and DATA_VALID are unchanged.
  - The FSM returns to IDLE at the final decision cycle, without waiting for count P-1. This lets a following start bit be caught early.
- Parity and stop errors can pulse together in the same cycle.
- Reset, asynchronous at any point including mid-frame:
  - FSM goes to IDLE; counters and shift register clear.
  - All outputs go to 0, including P_DATA.
  - The synchroniser resets to 1.

## Timing
- N = 1 + DATAWIDTH + PAR_EN + 1 + STOP2.
- Let t be the first cycle in which `rxs` = 0 in IDLE.
  - Final decision at t + (N-1)·P + h + 1.
  - Result pulses at t + (N-1)·P + h + 2.
- Add 2 cycles for the delay from the RX_IN edge to `rxs`.
- Example: P=8, DATAWIDTH=8, no parity, one stop bit gives DATA_VALID at t+78.
- A new start bit may begin anywhere from the cycle after the final decision onward.
- All output pulses are exactly 1 cycle wide and come straight from flops.

## Configuration
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - A break is a frame in which every voted bit is 0, including data, parity and stop bits.
  - On a break, BREAK_DET pulses instead of STOP_ERROR and PARITY_ERROR, and DATA_VALID does not pulse.
  - The FSM then enters BRK_WAIT and stays there until `rxs` = 1, then goes to IDLE.
- Undefined:
  - BREAK_DET is tied to 0 and BRK_WAIT is not built.
  - An all-zero frame reports STOP_ERROR. The FSM returns to IDLE and, because the line is still low, starts a new frame on the next cycle.

## Test plan
- P=8, DW=8, no parity, 1 stop, send 0xA5 → DATA_VALID pulse at t+78 with P_DATA=0xA5; no error flags.
- P=16, DW=7, PAR_EN=1, PAR_TYP=0, send 0x55 with parity bit 1 → PARITY_ERROR pulse; P_DATA keeps its previous value; DATA_VALID stays 0.
- P=8, STOP2=1, second stop bit driven 0 → STOP_ERROR pulse. A back-to-back next frame 0x3C is then received correctly.
- 2-cycle low pulse on RX_IN with P=8 → STR_GLITCH pulse; FSM returns to IDLE; no DATA_VALID.
- RX_IN held low for 3 frame times:
  - With UART_RX_BREAK_DETECT_EN: exactly one BREAK_DET pulse, then the FSM waits in BRK_WAIT.
  - Without it: a STOP_ERROR pulse for each frame.
- Assert RST mid-DATA → all outputs 0 immediately. The next frame, 0x81, is received correctly.

Source files
------------

// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2 - oversampling UART receiver with 3-sample majority voting.
//
// Frame format: start bit, DATAWIDTH data bits (LSB first), optional parity
// bit, then one or two stop bits. The bit period is PRESCALE clock cycles,
// with a minimum of 4. The frame configuration is captured when a start bit
// is first seen.
//
// Ports:
//   CLK          oversampling clock (only clock)
//   RST          asynchronous active-low reset
//   RX_IN        serial line, idles high
//   PRESCALE     clock cycles per bit (values below 4 act as 4)
//   PAR_EN       parity bit present
//   PAR_TYP      0 = even parity, 1 = odd parity
//   STOP2        two stop bits when 1
//   P_DATA       data of the last good frame
//   DATA_VALID   1-cycle pulse, P_DATA just updated
//   PARITY_ERROR 1-cycle pulse on parity mismatch
//   STOP_ERROR   1-cycle pulse when a stop bit is voted 0
//   STR_GLITCH   1-cycle pulse when a start bit is voted 1
//   BREAK_DET    1-cycle pulse on an all-zero frame
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN. When it is defined, an
// all-zero frame raises BREAK_DET and the receiver waits for the line to go
// high again. When it is undefined, BREAK_DET is tied low and an all-zero
// frame is reported as STOP_ERROR.
module uart_rx_gen2 #(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_IN,
    input  logic [5:0]           PRESCALE,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 STOP2,
    output logic [DATAWIDTH-1:0] P_DATA,
    output logic                 DATA_VALID,
    output logic                 PARITY_ERROR,
    output logic                 STOP_ERROR,
    output logic                 STR_GLITCH,
    output logic                 BREAK_DET
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, STOP_B
`ifdef UART_RX_BREAK_DETECT_EN
        , BRK_WAIT
`endif
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATAWIDTH - 1);

    state_t                 state;
    logic                   rx_meta, rxs;
    logic [5:0]             edge_cnt, p_lat;
    logic [3:0]             bit_idx;
    logic [DATAWIDTH-1:0]   shift_reg;
    logic                   smp0, smp1;
    logic                   par_acc, par_err_r, stop_err_r;
    logic                   par_en_lat, par_typ_lat, stop2_lat;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   all_zero;
`endif

    logic [5:0] p_in, half;
    logic       at_smp0, at_smp1, at_dec, at_end, vote;
    logic       frame_end, stop_err_fin;

    always_comb begin
        p_in         = (PRESCALE < 6'd4) ? 6'd4 : PRESCALE;
        half         = p_lat >> 1;
        at_smp0      = (edge_cnt == half - 6'd1);
        at_smp1      = (edge_cnt == half);
        at_dec       = (edge_cnt == half + 6'd1);
        at_end       = (edge_cnt == p_lat - 6'd1);
        // third sample is the live line value in the decision cycle
        vote         = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
        frame_end    = at_dec && (((state == STOP) && !stop2_lat) || (state == STOP_B));
        stop_err_fin = stop_err_r | ~vote;
    end

    // Two-flop synchroniser, resets to the idle (high) line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            p_lat        <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            smp0         <= 1'b0;
            smp1         <= 1'b0;
            par_acc      <= 1'b0;
            par_err_r    <= 1'b0;
            stop_err_r   <= 1'b0;
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            stop2_lat    <= 1'b0;
            P_DATA       <= '0;
            DATA_VALID   <= 1'b0;
            PARITY_ERROR <= 1'b0;
            STOP_ERROR   <= 1'b0;
            STR_GLITCH   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero     <= 1'b0;
            BREAK_DET    <= 1'b0;
`endif
        end else begin
            DATA_VALID   <= 1'b0;
            PARITY_ERROR <= 1'b0;
            STOP_ERROR   <= 1'b0;
            STR_GLITCH   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK_DET    <= 1'b0;
`endif
            if (state != IDLE) begin
                edge_cnt <= at_end ? '0 : edge_cnt + 6'd1;
                if (at_smp0) smp0 <= rxs;
                if (at_smp1) smp1 <= rxs;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        // this cycle is count 0 of the start bit
                        state       <= START;
                        edge_cnt    <= 6'd1;
                        p_lat       <= p_in;
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
                        stop2_lat   <= STOP2;
                        bit_idx     <= '0;
                        par_acc     <= 1'b0;
                        par_err_r   <= 1'b0;
                        stop_err_r  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero    <= 1'b1;
`endif
                    end
                end
                START: begin
                    if (at_dec && vote) begin
                        STR_GLITCH <= 1'b1;
                        state      <= IDLE;
                        edge_cnt   <= '0;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_dec) begin
                        shift_reg <= {vote, shift_reg[DATAWIDTH-1:1]};
                        par_acc   <= par_acc ^ vote;
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero  <= all_zero & ~vote;
`endif
                    end
                    if (at_end) begin
                        if (bit_idx == LAST_BIT) state <= par_en_lat ? PARITY : STOP;
                        else                     bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY: begin
                    if (at_dec) begin
                        par_err_r <= (vote != (par_acc ^ par_typ_lat));
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero  <= all_zero & ~vote;
`endif
                    end
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    // single-stop frames finish via frame_end below
                    if (stop2_lat) begin
                        if (at_dec) begin
                            stop_err_r <= ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
                            all_zero   <= all_zero & ~vote;
`endif
                        end
                        if (at_end) state <= STOP_B;
                    end
                end
                STOP_B: begin
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BRK_WAIT: begin
                    edge_cnt <= '0;
                    if (rxs) state <= IDLE;
                end
`endif
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase

            // Frame completes at the final stop decision, not at the bit end,
            // so a following start bit can be picked up early.
            if (frame_end) begin
                state    <= IDLE;
                edge_cnt <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
                if (all_zero && !vote) begin
                    BREAK_DET <= 1'b1;
                    state     <= BRK_WAIT;
                end else
`endif
                if (par_err_r || stop_err_fin) begin
                    PARITY_ERROR <= par_err_r;
                    STOP_ERROR   <= stop_err_fin;
                end else begin
                    P_DATA     <= shift_reg;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

`ifndef UART_RX_BREAK_DETECT_EN
    assign BREAK_DET = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen2.sv
// tb_uart_rx_gen2 - scoreboard bench for uart_rx_gen2 (DATAWIDTH = 8).
// Expected results are queued as frames are driven and are matched against
// every output pulse seen on the falling clock edge.
module tb_uart_rx_gen2;

    localparam int DW = 8;

    localparam logic [4:0] F_VALID  = 5'b00001;
    localparam logic [4:0] F_PAR    = 5'b00010;
    localparam logic [4:0] F_STOP   = 5'b00100;
    localparam logic [4:0] F_GLITCH = 5'b01000;
    localparam logic [4:0] F_BREAK  = 5'b10000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [5:0]    PRESCALE;
    logic          PAR_EN, PAR_TYP, STOP2;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID, PARITY_ERROR, STOP_ERROR, STR_GLITCH, BREAK_DET;

    typedef struct {
        logic [4:0]    flags;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] last_good = '0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_valid_cyc = -1;
    int            start_cyc;
    logic [4:0]    mon_f;
    exp_t          mon_e;

    uart_rx_gen2 #(.DATAWIDTH(DW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PRESCALE     (PRESCALE),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .STOP2        (STOP2),
        .P_DATA       (P_DATA),
        .DATA_VALID   (DATA_VALID),
        .PARITY_ERROR (PARITY_ERROR),
        .STOP_ERROR   (STOP_ERROR),
        .STR_GLITCH   (STR_GLITCH),
        .BREAK_DET    (BREAK_DET)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        mon_f = {BREAK_DET, STR_GLITCH, STOP_ERROR, PARITY_ERROR, DATA_VALID};
        if (mon_f != 5'b0) begin
            if (DATA_VALID) last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(mon_f), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("flags", 32'(mon_f), 32'(mon_e.flags));
                check("p_data", 32'(P_DATA), 32'(mon_e.data));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [4:0] f, input logic [DW-1:0] d);
        exp_t e;
        e.flags = f;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Drives one frame with the current configuration and queues its result.
    // With disturb set, the configuration inputs change after the start bit.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic par_bit,
                              input logic stop_a, input logic stop_b, input bit disturb);
        logic       pen, ptyp, s2, perr, serr;
        logic [5:0] psave;
        pen   = PAR_EN;
        ptyp  = PAR_TYP;
        s2    = STOP2;
        psave = PRESCALE;
        perr  = pen && (par_bit != ((^d) ^ ptyp));
        serr  = !stop_a || (s2 && !stop_b);
        if (perr || serr) begin
            push((perr ? F_PAR : 5'b0) | (serr ? F_STOP : 5'b0), last_good);
        end else begin
            push(F_VALID, d);
            last_good = d;
        end
        drive_bit(1'b0, p);
        if (disturb) begin
            PRESCALE = 6'd20;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
            STOP2    = ~s2;
        end
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pen) drive_bit(par_bit, p);
        drive_bit(stop_a, p);
        if (s2) drive_bit(stop_b, p);
        RX_IN = 1'b1;
        if (disturb) begin
            PRESCALE = psave;
            PAR_EN   = pen;
            PAR_TYP  = ptyp;
            STOP2    = s2;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
        idle(20);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        idle(3);
        check("rst_p_data", 32'(P_DATA), 32'd0);
        check("rst_flags", 32'({BREAK_DET, STR_GLITCH, STOP_ERROR, PARITY_ERROR, DATA_VALID}), 32'd0);
        RST = 1'b1;
        idle(4);

        // 8N1 at P=8: result 2 sync cycles + (N-1)*P + h + 2 after the edge
        start_cyc = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(200);
        check("latency", 32'(last_valid_cyc - start_cyc), 32'(2 + 9 * 8 + 4 + 2));

        // parity: wrong even parity, right odd parity, right even parity
        PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h55, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain(400);
        PAR_TYP = 1'b1;
        send_frame(8'h55, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain(400);
        PAR_TYP = 1'b0;
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain(400);

        // two stop bits, second one low, then a back-to-back good frame
        PRESCALE = 6'd8; PAR_EN = 1'b0; STOP2 = 1'b1;
        send_frame(8'h99, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(300);
        STOP2 = 1'b0;

        // 2-cycle low glitch
        push(F_GLITCH, last_good);
        drive_bit(1'b0, 2);
        RX_IN = 1'b1;
        wait_drain(100);

        // prescale below 4 behaves as 4
        PRESCALE = 6'd2;
        send_frame(8'h5A, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(100);

        // config inputs changing mid-frame do not affect it
        PRESCALE = 6'd8;
        send_frame(8'hC3, 8, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_drain(200);

        // line held low for about three frame times
`ifdef UART_RX_BREAK_DETECT_EN
        push(F_BREAK, last_good);
        drive_bit(1'b0, 250);
        RX_IN = 1'b1;
        idle(10);
        check("break_sb_empty", 32'(sb.size()), 32'd0);
        send_frame(8'h66, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(200);
`else
        for (int i = 0; i < 3; i++) push(F_STOP, last_good);
        drive_bit(1'b0, 250);
        check("hold_low_sb_empty", 32'(sb.size()), 32'd0);
        RST = 1'b0;
        #1;
        last_good = '0;
        RX_IN = 1'b1;
        idle(3);
        RST = 1'b1;
        idle(4);
`endif

        // reset in the middle of the data bits
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        RST = 1'b0;
        #1;
        check("rst_mid_p_data", 32'(P_DATA), 32'd0);
        check("rst_mid_flags", 32'({BREAK_DET, STR_GLITCH, STOP_ERROR, PARITY_ERROR, DATA_VALID}), 32'd0);
        last_good = '0;
        RX_IN = 1'b1;
        idle(3);
        RST = 1'b1;
        idle(4);
        send_frame(8'h81, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain(200);

        idle(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
